// File: rtl/hazard_pipe_tracker.sv
// -----------------------------------------------------------------------------
// hazard_pipe_tracker
//
// Purpose:
//   Tracks the register-usage fields of the instructions in the execute,
//   memory and writeback stages of a 5-stage pipeline, detects the
//   load-use hazard against the instruction in decode, and produces the
//   fetch/decode stall and decode/execute flush controls. The M and W
//   destination/write-enable pairs are the forwarding inputs of the
//   hazard unit. A saturating counter records how many load-use stall
//   cycles occurred since reset.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   RegSource1D/RegSource2D/RegDestinD decode-stage register numbers
//   RegWriteD, MemReadD               decode-stage writes-reg / is-load
//   PCSrcE                            branch/jump taken in execute
//   RegSource1E/RegSource2E/RegDestinE execute-stage register numbers
//   RegWriteE, MemReadE               execute-stage flags
//   RegDestinM/RegWriteM              memory-stage destination / write enable
//   RegDestinW/RegWriteW              writeback-stage destination / write enable
//   StallF, StallD, FlushD, FlushE    pipeline control (combinational)
//   StallCount                        load-use stall cycles, saturates at FFFF
// -----------------------------------------------------------------------------
module hazard_pipe_tracker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  RegSource1D,
    input  logic [4:0]  RegSource2D,
    input  logic [4:0]  RegDestinD,
    input  logic        RegWriteD,
    input  logic        MemReadD,
    input  logic        PCSrcE,
    output logic [4:0]  RegSource1E,
    output logic [4:0]  RegSource2E,
    output logic [4:0]  RegDestinE,
    output logic        RegWriteE,
    output logic        MemReadE,
    output logic [4:0]  RegDestinM,
    output logic [4:0]  RegDestinW,
    output logic        RegWriteM,
    output logic        RegWriteW,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic [15:0] StallCount
);

    localparam logic [15:0] StallCountMax = 16'hFFFF;

    logic lwStall;
    logic srcMatch;
    logic destNonZeroD;
    logic destNonZeroE;

    // ------------------------------------------------------------------
    // Load-use detection. A load to x0 never produces a usable value, so
    // it must not stall even if decode reads x0.
    // ------------------------------------------------------------------
    always_comb begin
        destNonZeroE = (RegDestinE != 5'd0);
        srcMatch     = (RegDestinE == RegSource1D) || (RegDestinE == RegSource2D);
        lwStall      = MemReadE && destNonZeroE && srcMatch;
    end

    always_comb begin
        StallF = lwStall;
        StallD = lwStall;
        FlushD = PCSrcE;
        FlushE = lwStall || PCSrcE;
    end

    // Write enable is qualified here so x0 can never be reported as a
    // pending write in any later stage.
    assign destNonZeroD = (RegDestinD != 5'd0);

    // ------------------------------------------------------------------
    // Decode -> execute register. A flush (stall bubble or taken branch)
    // inserts an all-zero entry; because the bubble clears MemReadE, a
    // load-use stall lasts exactly one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegSource1E <= 5'd0;
            RegSource2E <= 5'd0;
            RegDestinE  <= 5'd0;
            RegWriteE   <= 1'b0;
            MemReadE    <= 1'b0;
        end else if (FlushE) begin
            RegSource1E <= 5'd0;
            RegSource2E <= 5'd0;
            RegDestinE  <= 5'd0;
            RegWriteE   <= 1'b0;
            MemReadE    <= 1'b0;
        end else begin
            RegSource1E <= RegSource1D;
            RegSource2E <= RegSource2D;
            RegDestinE  <= RegDestinD;
            RegWriteE   <= RegWriteD && destNonZeroD;
            MemReadE    <= MemReadD;
        end
    end

    // ------------------------------------------------------------------
    // Execute -> memory -> writeback. These stages never stall or flush.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegDestinM <= 5'd0;
            RegWriteM  <= 1'b0;
            RegDestinW <= 5'd0;
            RegWriteW  <= 1'b0;
        end else begin
            RegDestinM <= RegDestinE;
            RegWriteM  <= RegWriteE;
            RegDestinW <= RegDestinM;
            RegWriteW  <= RegWriteM;
        end
    end

    // ------------------------------------------------------------------
    // Stall-cycle counter, saturating so long runs never read back small.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= 16'd0;
        end else if (lwStall && (StallCount != StallCountMax)) begin
            StallCount <= StallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
module tb_hazard_pipe_tracker;

    logic        clk;
    logic        rst_n;
    logic [4:0]  RegSource1D, RegSource2D, RegDestinD;
    logic        RegWriteD, MemReadD, PCSrcE;
    logic [4:0]  RegSource1E, RegSource2E, RegDestinE;
    logic        RegWriteE, MemReadE;
    logic [4:0]  RegDestinM, RegDestinW;
    logic        RegWriteM, RegWriteW;
    logic        StallF, StallD, FlushD, FlushE;
    logic [15:0] StallCount;

    int checks   = 0;
    int failures = 0;

    hazard_pipe_tracker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RegSource1D (RegSource1D),
        .RegSource2D (RegSource2D),
        .RegDestinD  (RegDestinD),
        .RegWriteD   (RegWriteD),
        .MemReadD    (MemReadD),
        .PCSrcE      (PCSrcE),
        .RegSource1E (RegSource1E),
        .RegSource2E (RegSource2E),
        .RegDestinE  (RegDestinE),
        .RegWriteE   (RegWriteE),
        .MemReadE    (MemReadE),
        .RegDestinM  (RegDestinM),
        .RegDestinW  (RegDestinW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .StallCount  (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the pipeline is a list of issued instructions,
    // index 0 = execute, 1 = memory, 2 = writeback. Bubbles are all-zero.
    typedef struct packed {
        logic [4:0] s1;
        logic [4:0] s2;
        logic [4:0] d;
        logic       rw;
        logic       mr;
    } instrT;

    instrT stages[$];
    int    modelStalls;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit writes(input instrT i);
        return i.rw && (i.d != 5'd0);
    endfunction

    function automatic bit modelLoadUse();
        instrT e;
        e = stages[0];
        return e.mr && (e.d != 5'd0) && (e.d == RegSource1D || e.d == RegSource2D);
    endfunction

    function automatic int expCount();
        return (modelStalls > 65535) ? 65535 : modelStalls;
    endfunction

    task automatic modelReset();
        stages.delete();
        for (int i = 0; i < 3; i++) stages.push_back('0);
        modelStalls = 0;
    endtask

    task automatic compareAll();
        bit lw;
        lw = modelLoadUse();
        checkVal("StallF",      StallF,      lw);
        checkVal("StallD",      StallD,      lw);
        checkVal("FlushD",      FlushD,      PCSrcE);
        checkVal("FlushE",      FlushE,      lw || PCSrcE);
        checkVal("RegSource1E", RegSource1E, stages[0].s1);
        checkVal("RegSource2E", RegSource2E, stages[0].s2);
        checkVal("RegDestinE",  RegDestinE,  stages[0].d);
        checkVal("RegWriteE",   RegWriteE,   writes(stages[0]));
        checkVal("MemReadE",    MemReadE,    stages[0].mr);
        checkVal("RegDestinM",  RegDestinM,  stages[1].d);
        checkVal("RegWriteM",   RegWriteM,   writes(stages[1]));
        checkVal("RegDestinW",  RegDestinW,  stages[2].d);
        checkVal("RegWriteW",   RegWriteW,   writes(stages[2]));
        checkVal("StallCount",  StallCount,  expCount());
    endtask

    task automatic driveD(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                          input logic rw, input logic mr, input logic pc);
        RegSource1D = s1;
        RegSource2D = s2;
        RegDestinD  = d;
        RegWriteD   = rw;
        MemReadD    = mr;
        PCSrcE      = pc;
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic runCycle(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                            input logic rw, input logic mr, input logic pc, input bit doCheck);
        bit    lw;
        instrT nxt;
        driveD(s1, s2, d, rw, mr, pc);
        #1;
        if (doCheck) compareAll();
        lw = modelLoadUse();
        nxt.s1 = s1; nxt.s2 = s2; nxt.d = d; nxt.rw = rw; nxt.mr = mr;
        @(posedge clk);
        if (lw) modelStalls++;
        if (lw || pc) nxt = '0;
        stages.push_front(nxt);
        void'(stages.pop_back());
        @(negedge clk);
    endtask

    // Asynchronous reset pulse starting mid-cycle, away from any edge.
    task automatic doReset();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        driveD(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        modelReset();
        @(negedge clk);
        compareAll();
        // FlushD follows PCSrcE even in reset; nothing else asserts.
        PCSrcE = 1'b1;
        #1;
        checkVal("rstFlushD", FlushD, 1'b1);
        checkVal("rstStallF", StallF, 1'b0);
        PCSrcE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Forwarding feed: dest 5 reaches M after 2 edges, W after 3.
        runCycle(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        runCycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("fwdDestM",  RegDestinM, 5'd5);
        checkVal("fwdWriteM", RegWriteM,  1'b1);
        runCycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("fwdDestW",  RegDestinW, 5'd5);
        checkVal("fwdWriteW", RegWriteW,  1'b1);

        // Load-use: exactly one stall cycle, bubble in E.
        doReset();
        runCycle(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        driveD(5'd7, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        #1;
        checkVal("luStallF", StallF, 1'b1);
        checkVal("luStallD", StallD, 1'b1);
        checkVal("luFlushE", FlushE, 1'b1);
        runCycle(5'd7, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        checkVal("luBubbleDest", RegDestinE, 5'd0);
        checkVal("luBubbleMr",   MemReadE,   1'b0);
        checkVal("luCount",      StallCount, 16'd1);
        driveD(5'd7, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        #1;
        checkVal("luReleased", StallF, 1'b0);
        runCycle(5'd7, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        checkVal("luIssued", RegSource1E, 5'd7);

        // Load to x0 never stalls and never writes.
        runCycle(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        driveD(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
        #1;
        checkVal("x0NoStall",  StallF,    1'b0);
        checkVal("x0NoWriteE", RegWriteE, 1'b0);
        checkVal("x0LoadE",    MemReadE,  1'b1);
        runCycle(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);

        // Branch flush.
        driveD(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
        #1;
        checkVal("brFlushD", FlushD, 1'b1);
        checkVal("brFlushE", FlushE, 1'b1);
        runCycle(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        checkVal("brDestE",  RegDestinE, 5'd0);
        checkVal("brWriteE", RegWriteE,  1'b0);

        // Branch and load-use together: one bubble.
        runCycle(5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        runCycle(5'd6, 5'd6, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        checkVal("bothBubble", RegDestinE, 5'd0);

        // Reset mid-pipe clears W immediately, then D loads normally.
        runCycle(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        runCycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        runCycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("preRstDestW", RegDestinW, 5'd9);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("rstDestW",  RegDestinW, 5'd0);
        checkVal("rstWriteW", RegWriteW,  1'b0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        runCycle(5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        checkVal("postRstDestE", RegDestinE, 5'd11);

        // Randomized traffic; small register range keeps hazards frequent.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) doReset();
            runCycle(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 2), 1'b1);
        end

        // Saturation: each load/use pair yields one stall cycle.
        doReset();
        for (int n = 0; n < 65537; n++) begin
            runCycle(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
            runCycle(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkVal("satCount", StallCount, 16'hFFFF);
        runCycle(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        runCycle(5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("satHold", StallCount, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_pipe_tracker.md
HAZARD_PIPE_TRACKER -- requirements
Module: hazard_pipe_tracker

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs RegSource1D, RegSource2D, input, 5 each, decode-stage source register numbers.
REQ-004 SHALL have input RegDestinD, input, 5, decode-stage destination register number.
REQ-005 SHALL have inputs RegWriteD, MemReadD, input, 1 each, decode-stage writes-register / is-load flags.
REQ-006 SHALL have input PCSrcE, input, 1, branch/jump taken in execute.
REQ-007 SHALL have outputs RegSource1E, RegSource2E, RegDestinE, output, 5 each, execute-stage register numbers.
REQ-008 SHALL have outputs RegWriteE, MemReadE, output, 1 each, execute-stage flags.
REQ-009 SHALL have outputs RegDestinM, RegDestinW, output, 5 each, memory/writeback destinations, which feed hazard_unit.
REQ-010 SHALL have outputs RegWriteM, RegWriteW, output, 1 each, memory/writeback write enables, which feed hazard_unit.
REQ-011 SHALL have outputs StallF, StallD, FlushD, FlushE, output, 1 each, pipeline control.
REQ-012 SHALL have output StallCount, output, 16, number of load-use stall cycles since reset.

Function
REQ-013 SHALL compute lwStall combinationally: MemReadE & (RegDestinE != 0) & (RegDestinE == RegSource1D | RegDestinE == RegSource2D).
REQ-014 SHALL drive StallF = StallD = lwStall, FlushD = PCSrcE, and FlushE = lwStall | PCSrcE, all combinationally.
REQ-015 SHALL, on each edge when FlushE=0, load the D fields into the E register: sources, destination, MemReadE <= MemReadD, and RegWriteE <= RegWriteD & (RegDestinD != 0).
REQ-016 SHALL, on each edge when FlushE=1, load a bubble into the E register: all 5-bit fields 0, RegWriteE=0, MemReadE=0.
REQ-017 SHALL advance E->M (RegDestinM, RegWriteM) and M->W (RegDestinW, RegWriteW) every cycle, unconditionally, with latency 1 per stage.
REQ-018 SHALL guarantee that a destination of x0 never produces RegWriteE/M/W=1.
REQ-019 SHALL let PCSrcE and lwStall in the same cycle produce a single bubble in E and a FlushD assertion.
REQ-020 SHALL increment StallCount by 1 on each edge where lwStall=1, saturating at 16'hFFFF with no wrap.
REQ-021 SHALL make a load followed by a dependent instruction stall exactly 1 cycle, because the bubble clears MemReadE.

Reset
REQ-022 SHALL, while rst_n=0, force all E/M/W register fields to 0, all flags to 0, and StallCount to 0, asynchronously.
REQ-023 SHALL hold StallF, StallD, FlushD and FlushE at 0 during reset except FlushD, which follows PCSrcE; with MemReadE=0, lwStall=0.
REQ-024 SHALL, when reset is asserted mid-operation, discard in-flight entries; the first edge after deassertion loads the D inputs normally.

Verification
REQ-025 SHALL verify forwarding feed: D={dest=5, RegWrite=1}, then idle -> RegDestinM=5/RegWriteM=1 after 2 edges, and RegDestinW=5/RegWriteW=1 after 3 edges.
REQ-026 SHALL verify load-use: load D={dest=7, MemRead=1}, next D={src1=7} -> StallF=StallD=FlushE=1 for 1 cycle, bubble in E, StallCount=1, then lwStall=0.
REQ-027 SHALL verify no false stall: load dest=0 followed by src1=0 -> lwStall=0, RegWriteE=0.
REQ-028 SHALL verify branch flush: PCSrcE=1 with D={dest=3, RegWrite=1} -> FlushD=1, FlushE=1, next RegDestinE=0/RegWriteE=0.
REQ-029 SHALL verify saturation: force 65536 stall cycles -> StallCount holds 16'hFFFF.
REQ-030 SHALL verify reset mid-pipe: assert rst_n=0 with W holding dest=9 -> RegDestinW=0 and RegWriteW=0 immediately, without waiting for a clock edge.
